// File: rtl/conf_int_mac_issuer.sv
// conf_int_mac_issuer
// Issues one operand set at a time to an external combinational MAC, waits a
// configurable number of settle cycles, then captures the MAC result and holds
// it behind a valid/ready handshake. Supports an approximate mode that zeroes
// the low Pn bits of a and b, and an accumulate mode that feeds the previous
// result back in as c.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake (in_ready only while idle)
//   in_a, in_b, in_c         operands
//   apx_en                   zero a[Pn-1:0] and b[Pn-1:0] for this transaction
//   acc_en, acc_clr          use / clear the accumulator as c
//   mac_a, mac_b, mac_c      registered operands driven to the MAC
//   mac_a_h, mac_b_h         mac_a / mac_b bits [31:Pn]
//   mac_c_h                  mac_c bits [31:2*Pn]
//   mac_d                    MAC result (combinational from mac_*)
//   out_valid / out_ready    result handshake
//   out_d                    registered result
//   op_count                 completed transaction count (wraps)
module conf_int_mac_issuer #(
    parameter int unsigned OP_BITWIDTH        = 32,
    parameter int unsigned DATA_PATH_BITWIDTH = 32,
    parameter int unsigned Pn                 = 12,
    parameter int unsigned SETTLE_CYCLES      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0]         in_a,
    input  logic [DATA_PATH_BITWIDTH-1:0]         in_b,
    input  logic [DATA_PATH_BITWIDTH-1:0]         in_c,
    input  logic                                  apx_en,
    input  logic                                  acc_en,
    input  logic                                  acc_clr,
    output logic [DATA_PATH_BITWIDTH-1:0]         mac_a,
    output logic [DATA_PATH_BITWIDTH-1:0]         mac_b,
    output logic [DATA_PATH_BITWIDTH-1:0]         mac_c,
    output logic [DATA_PATH_BITWIDTH-Pn-1:0]      mac_a_h,
    output logic [DATA_PATH_BITWIDTH-Pn-1:0]      mac_b_h,
    output logic [DATA_PATH_BITWIDTH-2*Pn-1:0]    mac_c_h,
    input  logic [DATA_PATH_BITWIDTH-1:0]         mac_d,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0]         out_d,
    output logic [15:0]                           op_count
);

    localparam int unsigned DW         = DATA_PATH_BITWIDTH;
    localparam int unsigned OPC_W      = 16;
    // A settle time of zero still needs one cycle for the MAC inputs to be registered.
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);
    // Keeps bits [DW-1:Pn], clears the approximated low bits.
    localparam logic [DW-1:0] APX_MASK = {{(DW-Pn){1'b1}}, {Pn{1'b0}}};

    // Elaboration-time parameter sanity checks
    if (DATA_PATH_BITWIDTH != 32) begin : g_dw_check
        $error("conf_int_mac_issuer: DATA_PATH_BITWIDTH must be 32");
    end
    if ((Pn < 1) || (Pn > 15)) begin : g_pn_check
        $error("conf_int_mac_issuer: Pn must be in 1..15");
    end
    if (OP_BITWIDTH == 0) begin : g_op_check
        $error("conf_int_mac_issuer: OP_BITWIDTH must be nonzero");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   settle_q,    settle_d;
    logic [DW-1:0]      a_q,         a_d;
    logic [DW-1:0]      b_q,         b_d;
    logic [DW-1:0]      c_q,         c_d;
    logic [DW-1:0]      acc_q,       acc_d;
    logic [DW-1:0]      out_d_q,     out_d_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic [OPC_W-1:0]   op_count_q,  op_count_d;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        acc_d       = acc_q;
        out_d_d     = out_d_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d = apx_en ? (in_a & APX_MASK) : in_a;
                    b_d = apx_en ? (in_b & APX_MASK) : in_b;
                    if (acc_en) begin
                        c_d = acc_clr ? '0 : acc_q;
                    end else begin
                        c_d = in_c;
                    end
                    // Clear applies even when the accumulator is not selected as c.
                    if (acc_clr) begin
                        acc_d = '0;
                    end
                    settle_d = CNT_LOAD;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (settle_q == '0) begin
                    out_d_d     = mac_d;
                    acc_d       = mac_d;
                    out_valid_d = 1'b1;
                    op_count_d  = op_count_q + OPC_W'(1);
                    state_d     = ST_HOLD;
                end else begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so in_ready tracks the state without a decode on the output.
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            op_count_q  <= op_count_d;
        end
    end

    // MAC operands come only from the operand registers; high ports are slices of them.
    assign mac_a     = a_q;
    assign mac_b     = b_q;
    assign mac_c     = c_q;
    assign mac_a_h   = a_q[DW-1:Pn];
    assign mac_b_h   = b_q[DW-1:Pn];
    assign mac_c_h   = c_q[DW-1:2*Pn];
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_conf_int_mac_issuer.sv
// Testbench for conf_int_mac_issuer: two instances (settle 1 and settle 4)
// driven by directed and random stimulus, checked every cycle against a
// transaction-level model, plus literal expectations for the known vectors.
module tb_conf_int_mac_issuer;

    localparam int unsigned PN = 12;
    localparam int unsigned HW = 32 - PN;
    localparam int unsigned CW = 32 - 2 * PN;

    logic clk;
    logic rst_s       [2];
    logic vld_s       [2];
    logic rdy_s       [2];
    logic [31:0] in_a, in_b, in_c;
    logic apx_en, acc_en, acc_clr;

    logic        in_ready_w  [2];
    logic [31:0] mac_a_w     [2];
    logic [31:0] mac_b_w     [2];
    logic [31:0] mac_c_w     [2];
    logic [HW-1:0] mac_a_h_w [2];
    logic [HW-1:0] mac_b_h_w [2];
    logic [CW-1:0] mac_c_h_w [2];
    logic [31:0] mac_d_w     [2];
    logic        out_valid_w [2];
    logic [31:0] out_d_w     [2];
    logic [15:0] op_count_w  [2];

    int total = 0;
    int bad   = 0;

    // Behavioural combinational MACs, one per instance
    assign mac_d_w[0] = mac_a_w[0] * mac_b_w[0] + mac_c_w[0];
    assign mac_d_w[1] = mac_a_w[1] * mac_b_w[1] + mac_c_w[1];

    conf_int_mac_issuer #(
        .OP_BITWIDTH(32), .DATA_PATH_BITWIDTH(32), .Pn(PN), .SETTLE_CYCLES(1)
    ) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .in_valid(vld_s[0]), .in_ready(in_ready_w[0]),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .apx_en(apx_en),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .mac_a(mac_a_w[0]), .mac_b(mac_b_w[0]), .mac_c(mac_c_w[0]),
        .mac_a_h(mac_a_h_w[0]), .mac_b_h(mac_b_h_w[0]), .mac_c_h(mac_c_h_w[0]),
        .mac_d(mac_d_w[0]), .out_valid(out_valid_w[0]), .out_ready(rdy_s[0]),
        .out_d(out_d_w[0]), .op_count(op_count_w[0])
    );

    conf_int_mac_issuer #(
        .OP_BITWIDTH(32), .DATA_PATH_BITWIDTH(32), .Pn(PN), .SETTLE_CYCLES(4)
    ) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .in_valid(vld_s[1]), .in_ready(in_ready_w[1]),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .apx_en(apx_en),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .mac_a(mac_a_w[1]), .mac_b(mac_b_w[1]), .mac_c(mac_c_w[1]),
        .mac_a_h(mac_a_h_w[1]), .mac_b_h(mac_b_h_w[1]), .mac_c_h(mac_c_h_w[1]),
        .mac_d(mac_d_w[1]), .out_valid(out_valid_w[1]), .out_ready(rdy_s[1]),
        .out_d(out_d_w[1]), .op_count(op_count_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Transaction-level model state per instance
    logic [31:0] m_a [2], m_b [2], m_c [2], m_acc [2], m_d [2];
    logic [15:0] m_cnt [2];
    bit          m_busy [2], m_valid [2];
    int          m_due [2];

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic void model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst_s[i]) begin
                m_a[i] = 0; m_b[i] = 0; m_c[i] = 0; m_acc[i] = 0; m_d[i] = 0;
                m_cnt[i] = 0; m_busy[i] = 0; m_valid[i] = 0; m_due[i] = 0;
            end else if (!m_busy[i]) begin
                if (vld_s[i]) begin
                    m_a[i] = apx_en ? ((in_a >> PN) << PN) : in_a;
                    m_b[i] = apx_en ? ((in_b >> PN) << PN) : in_b;
                    if (acc_en) m_c[i] = acc_clr ? 32'd0 : m_acc[i];
                    else        m_c[i] = in_c;
                    if (acc_clr) m_acc[i] = 0;
                    m_due[i]  = settle_of(i);
                    m_busy[i] = 1;
                end
            end else if (!m_valid[i]) begin
                m_due[i] = m_due[i] - 1;
                if (m_due[i] == 0) begin
                    m_d[i]     = m_a[i] * m_b[i] + m_c[i];
                    m_acc[i]   = m_d[i];
                    m_cnt[i]   = m_cnt[i] + 16'd1;
                    m_valid[i] = 1;
                end
            end else if (rdy_s[i]) begin
                m_valid[i] = 0;
                m_busy[i]  = 0;
            end
        end
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk("in_ready",  i, 32'(in_ready_w[i]),  32'(!m_busy[i]));
            chk("out_valid", i, 32'(out_valid_w[i]), 32'(m_valid[i]));
            chk("out_d",     i, out_d_w[i],          m_d[i]);
            chk("op_count",  i, 32'(op_count_w[i]),  32'(m_cnt[i]));
            chk("mac_a",     i, mac_a_w[i],          m_a[i]);
            chk("mac_b",     i, mac_b_w[i],          m_b[i]);
            chk("mac_c",     i, mac_c_w[i],          m_c[i]);
            chk("mac_a_h",   i, 32'(mac_a_h_w[i]),   m_a[i] >> PN);
            chk("mac_b_h",   i, 32'(mac_b_h_w[i]),   m_b[i] >> PN);
            chk("mac_c_h",   i, 32'(mac_c_h_w[i]),   m_c[i] >> (2 * PN));
        end
    endtask

    // One clock: model advances on the edge, outputs compared just after it.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Issue one transaction and wait (bounded) until its result is held.
    task automatic run_txn(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic apx, input logic ae,
                           input logic ac, output logic [31:0] res, output int lat);
        in_a = a; in_b = b; in_c = c; apx_en = apx; acc_en = ae; acc_clr = ac;
        vld_s[i] = 1'b1;
        step();
        vld_s[i] = 1'b0;
        lat = 0;
        for (int k = 0; k < 10 && !out_valid_w[i]; k++) begin
            step();
            lat++;
        end
        chk("valid_seen", i, 32'(out_valid_w[i]), 32'd1);
        res = out_d_w[i];
    endtask

    task automatic drain(input int i);
        rdy_s[i] = 1'b1;
        step();
        rdy_s[i] = 1'b0;
        chk("drain_valid", i, 32'(out_valid_w[i]), 32'd0);
    endtask

    logic [31:0] res, held;
    int          lat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; vld_s[i] = 1'b0; rdy_s[i] = 1'b0;
        end
        in_a = 0; in_b = 0; in_c = 0; apx_en = 0; acc_en = 0; acc_clr = 0;
        repeat (3) step();
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;

        // Reset values
        chk("rst_in_ready",  0, 32'(in_ready_w[0]),  32'd1);
        chk("rst_out_valid", 0, 32'(out_valid_w[0]), 32'd0);
        chk("rst_out_d",     0, out_d_w[0],          32'd0);
        chk("rst_op_count",  0, 32'(op_count_w[0]),  32'd0);
        chk("rst_mac_c",     0, mac_c_w[0],          32'd0);

        // 3*5+7, one-cycle latency
        run_txn(0, 32'd3, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, res, lat);
        chk("basic_out_d", 0, res, 32'd22);
        chk("basic_lat",   0, 32'(lat), 32'd1);
        chk("basic_cnt",   0, 32'(op_count_w[0]), 32'd1);
        drain(0);
        chk("basic_ready_back", 0, 32'(in_ready_w[0]), 32'd1);

        // Approximate mode truncates the low Pn bits of a and b
        run_txn(0, 32'h1234, 32'h2003, 32'h0, 1'b1, 1'b0, 1'b0, res, lat);
        chk("apx_mac_a",   0, mac_a_w[0], 32'h1000);
        chk("apx_mac_a_h", 0, 32'(mac_a_h_w[0]), 32'h1);
        chk("apx_mac_b_h", 0, 32'(mac_b_h_w[0]), 32'h2);
        chk("apx_out_d",   0, res, 32'h0200_0000);
        drain(0);

        // Accumulate: cleared start, then feed back
        run_txn(0, 32'd2, 32'd3, 32'd99, 1'b0, 1'b1, 1'b1, res, lat);
        chk("acc_clr_out_d", 0, res, 32'd6);
        drain(0);
        run_txn(0, 32'd4, 32'd5, 32'd99, 1'b0, 1'b1, 1'b0, res, lat);
        chk("acc_out_d", 0, res, 32'd26);
        drain(0);

        // Modulo-2^32 wrap, then a long hold with a competing in_valid
        run_txn(0, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, res, lat);
        chk("wrap_out_d", 0, res, 32'd1);
        held = out_d_w[0];
        in_a = 32'hDEAD_BEEF; in_b = 32'd9; in_c = 32'd1;
        vld_s[0] = 1'b1;
        repeat (5) begin
            step();
            chk("hold_out_d",    0, out_d_w[0], held);
            chk("hold_in_ready", 0, 32'(in_ready_w[0]), 32'd0);
            chk("hold_mac_a",    0, mac_a_w[0], 32'hFFFF_FFFF);
        end
        vld_s[0] = 1'b0;
        drain(0);
        repeat (2) step();
        chk("hold_cnt",   0, 32'(op_count_w[0]), 32'd5);
        chk("hold_valid", 0, 32'(out_valid_w[0]), 32'd0);

        // Settle=4: reset during the second WAIT cycle aborts the transaction
        in_a = 32'd6; in_b = 32'd7; in_c = 32'd1; apx_en = 0; acc_en = 0; acc_clr = 0;
        vld_s[1] = 1'b1;
        step();
        vld_s[1] = 1'b0;
        step();
        rst_s[1] = 1'b1;
        step();
        rst_s[1] = 1'b0;
        chk("abort_in_ready", 1, 32'(in_ready_w[1]), 32'd1);
        chk("abort_out_d",    1, out_d_w[1], 32'd0);
        chk("abort_mac_a",    1, mac_a_w[1], 32'd0);
        repeat (6) begin
            step();
            chk("abort_no_valid", 1, 32'(out_valid_w[1]), 32'd0);
            chk("abort_cnt",      1, 32'(op_count_w[1]), 32'd0);
        end

        // Settle=4 latency
        run_txn(1, 32'd3, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, res, lat);
        chk("lat4",       1, 32'(lat), 32'd4);
        chk("lat4_out_d", 1, res, 32'd22);
        chk("lat4_cnt",   1, 32'(op_count_w[1]), 32'd1);
        drain(1);

        // Random traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                rst_s[i] = ($urandom_range(0, 299) == 0);
                vld_s[i] = ($urandom_range(0, 2) != 0);
                rdy_s[i] = ($urandom_range(0, 2) == 0);
            end
            in_a    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            in_b    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            in_c    = $urandom;
            apx_en  = 1'($urandom_range(0, 1));
            acc_en  = 1'($urandom_range(0, 1));
            acc_clr = ($urandom_range(0, 3) == 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b0; vld_s[i] = 1'b0; rdy_s[i] = 1'b1;
        end
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
